// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the fetch stage.
// FETCH_ALIGN_CHECK_EN adds the FAULT state used by the misaligned-target check.
package cpu_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;
`endif

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Sequential-PC adder: pc + INSTR_BYTES, wrapping modulo 2^32.
module pc_incrementer
  import cpu_fetch_pkg::*;
(
  input  logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + 32'(INSTR_BYTES);

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and single-outstanding instruction fetch for decode.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned next-PC targets into a sticky FAULT.
module fetch_pc_unit
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         imem_req_q, imem_req_d;
  logic         boot_q, boot_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic         misalign_q, misalign_d;
`else
  logic         unused_next_pc_lsbs;
  assign unused_next_pc_lsbs = ^next_pc[1:0];
`endif

  pc_incrementer u_pc_inc (
    .pc       (pc_q),
    .pc_plus4 (pc_plus4)
  );

  // boot_q holds IDLE for the one cycle after the reset-release edge.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    boot_d        = boot_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_d    = misalign_q;
`endif
    case (state_q)
      ST_IDLE: begin
        boot_d = 1'b1;
        if (boot_q) begin
          state_d    = ST_REQ;
          imem_req_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          instr_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
          pc_d = next_pc;
          if (next_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = ST_FAULT;
          end else begin
            imem_req_d = 1'b1;
            state_d    = ST_REQ;
          end
`else
          pc_d       = word_align(next_pc);
          imem_req_d = 1'b1;
          state_d    = ST_REQ;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      ST_FAULT: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
`endif
      default: begin
        state_d       = ST_IDLE;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      boot_q        <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      boot_q        <= boot_d;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = imem_req_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: behavioural model compared every cycle plus literal checkpoints.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        stall;
  logic [31:0] pc, pc_plus4, imem_addr, instr, imem_rdata;
  logic        imem_req, imem_ack, instr_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_pc_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (next_pc),
    .stall       (stall),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .misalign    (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model: what the fetch stage must show after each edge, from the behavioural rules.
  logic [31:0] m_pc, m_instr;
  bit          m_valid, m_req, m_mis, m_init;
  int          m_boot;

  initial m_init = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = 32'h0; m_valid = 0; m_req = 0; m_mis = 0;
      m_boot = 2; m_init = 1;
    end else if (!m_init || m_mis) begin
      // nothing changes before reset or once faulted
    end else if (m_boot > 0) begin
      m_boot--;
      m_req = (m_boot == 0);
    end else if (m_req) begin
      if (imem_ack) begin
        m_instr = imem_rdata; m_valid = 1; m_req = 0;
      end
    end else if (!stall) begin
      m_valid = 0;
`ifdef FETCH_ALIGN_CHECK_EN
      m_pc = next_pc;
      if (next_pc % 4 != 0) m_mis = 1;
      else m_req = 1;
`else
      m_pc  = next_pc - (next_pc % 4);
      m_req = 1;
`endif
    end
  end

  always @(posedge clk) begin
    #2;
    if (m_init) begin
      chk("cmp_pc", pc, m_pc);
      chk("cmp_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("cmp_imem_req", {31'b0, imem_req}, {31'b0, m_req});
      chk("cmp_instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      chk("cmp_instr", instr, m_instr);
      if (m_req) chk("cmp_imem_addr", imem_addr, m_pc);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("cmp_misalign", {31'b0, misalign}, {31'b0, m_mis});
`endif
    end
  end

  // Call at a negedge inside a REQ cycle; returns at a negedge inside HOLD.
  task automatic fetch(input logic [31:0] data, input int lat);
    repeat (lat) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; next_pc = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req", {31'b0, imem_req}, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h9999_9999;  // ack in IDLE must be ignored
    @(negedge clk);
    imem_ack = 1'b0;
    chk("req1_req", {31'b0, imem_req}, 32'h1);
    chk("req1_addr", imem_addr, 32'h0);
    chk("req1_valid", {31'b0, instr_valid}, 32'h0);

    @(negedge clk);
    next_pc = 32'h40;
    fetch(32'h2001_0005, 1);
    chk("fetch_instr", instr, 32'h2001_0005);
    chk("fetch_valid", {31'b0, instr_valid}, 32'h1);
    chk("fetch_req_low", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    chk("adv_pc", pc, 32'h40);
    chk("adv_addr", imem_addr, 32'h40);
    chk("adv_req", {31'b0, imem_req}, 32'h1);

    fetch(32'h1111_0001, 0);
    stall = 1'b1; next_pc = 32'h80;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 1); imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("stall_pc", pc, 32'h40);
      chk("stall_instr", instr, 32'h1111_0001);
      chk("stall_valid", {31'b0, instr_valid}, 32'h1);
      chk("stall_req", {31'b0, imem_req}, 32'h0);
    end
    imem_ack = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("unstall_pc", pc, 32'h80);
    chk("unstall_req", {31'b0, imem_req}, 32'h1);

    fetch(32'h2222_0002, 1);
    next_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    fetch(32'h3333_0003, 2);
    next_pc = pc_plus4;
    @(negedge clk);
    chk("wrap_pc_zero", pc, 32'h0);

    fetch(32'h4444_0004, 0);
    next_pc = 32'h42;
    @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_flag", {31'b0, misalign}, 32'h1);
    chk("mis_pc", pc, 32'h42);
    for (int i = 0; i < 6; i++) begin
      imem_ack = i[0]; imem_rdata = 32'h7777_7777;
      @(negedge clk);
      chk("mis_req", {31'b0, imem_req}, 32'h0);
      chk("mis_sticky", {31'b0, misalign}, 32'h1);
      chk("mis_valid", {31'b0, instr_valid}, 32'h0);
    end
    imem_ack = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mis_cleared", {31'b0, misalign}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
`else
    chk("align_pc", pc, 32'h40);
    chk("align_req", {31'b0, imem_req}, 32'h1);
`endif
    fetch(32'h5555_0005, 0);
    next_pc = 32'h100;
    @(negedge clk);
    chk("pre_rst_pc", pc, 32'h100);
    chk("pre_rst_req", {31'b0, imem_req}, 32'h1);

    imem_ack = 1'b1; imem_rdata = 32'h6666_0006; rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'b0, instr_valid}, 32'h0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_req", {31'b0, imem_req}, 32'h0);
    imem_ack = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    chk("midrst_req_again", {31'b0, imem_req}, 32'h1);
    chk("midrst_addr", imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and instruction-fetch stage of the CPU. Holds the architectural PC, supplies PC+4 to the 32-bit next-PC select mux, and loads the mux output as the new PC when the fetched instruction is consumed. Drives a single-outstanding request/acknowledge interface to instruction memory and presents one instruction at a time to decode, with a stall input from the pipeline.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- next_pc  input  32  next-PC select output (PC+4 or branch/jump target).
- stall  input  1  decode not ready; holds current instruction and PC.
- pc  output  32  current PC register.
- pc_plus4  output  32  combinational pc + 4, modulo 2^32; feeds next-PC select input 0.
- imem_req  output  1  fetch request; address valid while high.
- imem_addr  output  32  equals pc.
- imem_ack  input  1  memory has returned imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  registered instruction for decode.
- instr_valid  output  1  instr holds the instruction at pc.
- misalign  output  1  sticky misaligned-target fault; present only with FETCH_ALIGN_CHECK_EN.

## Operation
- States: IDLE, REQ, HOLD, FAULT (FAULT only with the macro).
- IDLE: imem_req=0; unconditionally → REQ next cycle.
- REQ: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, instr_valid<=1, → HOLD. No ack: stay. stall ignored in REQ; an issued request always completes.
- HOLD: instr_valid=1, imem_req=0. If stall: stay, pc and instr unchanged. If !stall: pc<=next_pc, instr_valid<=0, → REQ.
- imem_ack outside REQ is ignored; imem_rdata is not sampled.
- pc_plus4 wraps: pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000; no flag.
- next_pc is sampled only on the HOLD-to-REQ transition.

## Timing
- Reset values: pc=RESET_PC, pc_plus4=RESET_PC+4, imem_req=0, instr=0, instr_valid=0, misalign=0, state=IDLE.
- First imem_req high on the 2nd rising edge after rst_n deasserts. Reset ends with the edge that samples rst_n=1; the following cycle is IDLE, the cycle after is REQ.
- Ack in cycle N produces instr_valid=1 from cycle N+1.
- Consume at cycle M, defined as HOLD with !stall: new pc and imem_req=1 from cycle M+1. Minimum throughput is one instruction per 2 cycles plus memory latency.
- rst_n low at any edge overrides all state, including REQ with ack in the same cycle. The ack is discarded and the state goes to IDLE.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - On consume, if next_pc[1:0]!=2'b00, pc<=next_pc, misalign<=1, go to FAULT.
  - FAULT: imem_req=0, instr_valid=0. Stays there until reset.
  - misalign stays high until reset.
- Not defined:
  - No misalign port and no FAULT state.
  - pc<={next_pc[31:2],2'b00}, so pc[1:0] is always 0.

## Structure
- Package cpu_fetch_pkg: fetch state enum, default RESET_PC constant, INSTR_BYTES=4.
- Sub-module pc_incrementer: 32-bit pc to pc+4 adder. No other sub-modules.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release. Expect pc=0, pc_plus4=4, instr_valid=0, imem_req=0 during reset and the IDLE cycle, and imem_req=1 with imem_addr=0 on the next cycle.
- Fetch and advance:
  - Ack on the 3rd REQ cycle with rdata=32'h2001_0005 and next_pc=32'h40. Expect instr=32'h2001_0005 and instr_valid=1 on the next cycle.
  - With stall=0, expect pc=32'h40 and imem_addr=32'h40 one cycle later.
- Stall: hold stall=1 for 4 cycles in HOLD. Expect pc, instr and instr_valid unchanged and imem_req=0. Release stall; expect pc to advance one cycle later.
- Wrap: set next_pc=32'hFFFF_FFFC and consume. Expect pc_plus4=0. Then set next_pc=pc_plus4 and consume; expect pc=0.
- Alignment: set next_pc=32'h42.
  - With the macro: expect misalign=1, imem_req=0 indefinitely, until reset clears it.
  - Without the macro: expect pc=32'h40.
- Reset mid-request: assert rst_n=0 in a REQ cycle with imem_ack=1. Expect instr_valid=0, instr=0, pc=RESET_PC and state IDLE.
